// File: rtl/score_lcd_writer.sv
// score_lcd_writer: HD44780 8-bit write-only sequencer.
// After power-up it runs the init commands, then renders "P1:d  P2:d" on
// line 1. It re-renders whenever either score byte differs from the copy
// that was last written.
module score_lcd_writer #(
    parameter int POWERUP_WAIT = 750000,
    parameter int EN_PULSE     = 25,
    parameter int CMD_WAIT     = 2500,
    parameter int CLEAR_WAIT   = 100000
) (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic [7:0] in_player1,
    input  logic [7:0] in_player2,
    output logic [7:0] out_lcd_data,
    output logic       out_lcd_rs,
    output logic       out_lcd_rw,
    output logic       out_lcd_en,
    output logic       out_busy
);

    // SETUP/PULSE/HOLD/WAIT are the phases of one byte transfer. Which byte
    // is being sent, and whether it belongs to init or refresh, is held in idx_q.
    typedef enum logic [2:0] {
        ST_POWER_UP,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } state_t;

    // Sequence index: 0..3 are init commands, 4..14 are the refresh bytes.
    localparam logic [3:0] IDX_CLEAR   = 4'd2;
    localparam logic [3:0] IDX_REFRESH = 4'd4;
    localparam logic [3:0] IDX_LAST    = 4'd14;

    // Terminal counts for the shared delay counter (each phase counts from 0).
    localparam logic [19:0] PU_LAST    = 20'(POWERUP_WAIT - 1);
    localparam logic [19:0] EN_LAST    = 20'(EN_PULSE - 1);
    localparam logic [19:0] CMD_LAST   = 20'(CMD_WAIT - 1);
    localparam logic [19:0] CLEAR_LAST = 20'(CLEAR_WAIT - 1);

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  shadow1_q, shadow1_d;
    logic [7:0]  shadow2_q, shadow2_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;

    logic        mismatch;
    logic        load;
    logic [3:0]  load_idx;
    logic [19:0] wait_last;

    // {rs, data} for each position in the sequence.
    function automatic logic [8:0] seq_byte(input logic [3:0] idx,
                                            input logic [7:0] s1,
                                            input logic [7:0] s2);
        logic [8:0] b;
        case (idx)
            4'd0:    b = 9'h038;
            4'd1:    b = 9'h00C;
            4'd2:    b = 9'h001;
            4'd3:    b = 9'h006;
            4'd4:    b = 9'h080;
            4'd5:    b = 9'h150;
            4'd6:    b = 9'h131;
            4'd7:    b = 9'h13A;
            4'd8:    b = {1'b1, s1};
            4'd9:    b = 9'h120;
            4'd10:   b = 9'h120;
            4'd11:   b = 9'h150;
            4'd12:   b = 9'h132;
            4'd13:   b = 9'h13A;
            4'd14:   b = {1'b1, s2};
            default: b = 9'h000;
        endcase
        return b;
    endfunction

    // Next-state, counter, shadow and output-register logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shadow1_d = shadow1_q;
        shadow2_d = shadow2_q;
        data_d    = data_q;
        rs_d      = rs_q;
        en_d      = en_q;
        busy_d    = busy_q;
        load      = 1'b0;
        load_idx  = idx_q;
        mismatch  = (in_player1 != shadow1_q) || (in_player2 != shadow2_q);
        wait_last = (idx_q == IDX_CLEAR) ? CLEAR_LAST : CMD_LAST;

        case (state_q)
            ST_POWER_UP: begin
                if (cnt_q == PU_LAST) begin
                    load     = 1'b1;
                    load_idx = 4'd0;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            ST_SETUP: begin
                state_d = ST_PULSE;
                en_d    = 1'b1;
                cnt_d   = '0;
            end
            ST_PULSE: begin
                if (cnt_q == EN_LAST) begin
                    state_d = ST_HOLD;
                    en_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            ST_HOLD: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (cnt_q == wait_last) begin
                    cnt_d = '0;
                    if (idx_q != IDX_LAST) begin
                        // Init rolls straight into the first, unconditional refresh.
                        load     = 1'b1;
                        load_idx = idx_q + 4'd1;
                    end else if (mismatch) begin
                        // Change arrived mid-refresh: go again without dropping busy.
                        load     = 1'b1;
                        load_idx = IDX_REFRESH;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            ST_IDLE: begin
                busy_d = 1'b0;
                if (mismatch) begin
                    load     = 1'b1;
                    load_idx = IDX_REFRESH;
                end
            end
            default: begin
                state_d = ST_POWER_UP;
                cnt_d   = '0;
            end
        endcase

        // Start a byte transfer: present data/RS now, strobe on the next cycle.
        if (load) begin
            state_d = ST_SETUP;
            cnt_d   = '0;
            idx_d   = load_idx;
            busy_d  = 1'b1;
            if (load_idx == IDX_REFRESH) begin
                // Freeze the scores for the whole refresh.
                shadow1_d = in_player1;
                shadow2_d = in_player2;
            end
            {rs_d, data_d} = seq_byte(load_idx, shadow1_q, shadow2_q);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q   <= ST_POWER_UP;
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow1_q <= '0;
            shadow2_q <= '0;
            data_q    <= '0;
            rs_q      <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow1_q <= shadow1_d;
            shadow2_q <= shadow2_d;
            data_q    <= data_d;
            rs_q      <= rs_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
        end
    end

    assign out_lcd_data = data_q;
    assign out_lcd_rs   = rs_q;
    assign out_lcd_rw   = 1'b0;
    assign out_lcd_en   = en_q;
    assign out_busy     = busy_q;

endmodule
